// File: rtl/analog_axis_emu_pkg.sv
// Shared types, PS/2 packet field offsets and arithmetic helpers for the
// mouse-to-analog-axis emulator.
package analog_axis_pkg;

  typedef enum logic {JOY = 1'b0, MOUSE = 1'b1} state_t;

  localparam int unsigned PS2_STB     = 24;
  localparam int unsigned PS2_XSIGN   = 4;
  localparam int unsigned PS2_YSIGN   = 5;
  localparam int unsigned PS2_DX_LSB  = 8;
  localparam int unsigned PS2_DY_LSB  = 16;
  localparam int unsigned PS2_BTN_LSB = 0;

  function automatic int clamp_step(input int d, input int max_step);
    if (d > max_step) return max_step;
    if (d < -max_step) return -max_step;
    return d;
  endfunction

  // Saturating add into a signed axw-bit range; the sum is formed wide so
  // a single out-of-range step can never wrap.
  function automatic int sat_add(input int acc, input int d, input int axw);
    int hi;
    int lo;
    int s;
    hi = (1 << (axw - 1)) - 1;
    lo = -(1 << (axw - 1));
    s  = acc + d;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/analog_axis_emu_if.sv
// Per-port joystick bus between hps_io and the core: stick/button inputs in,
// emulated or passed-through axis/button values out.
interface analog_axis_emu_if #(
  parameter int NPORT = 2,
  parameter int AXW   = 8
);
  logic [NPORT*16-1:0]  joya;
  logic [NPORT*21-1:0]  joy_in;
  logic [NPORT*AXW-1:0] ax_out;
  logic [NPORT*AXW-1:0] ay_out;
  logic [NPORT*21-1:0]  joy_out;
  logic [NPORT-1:0]     emu_active;

  modport master (output joya, joy_in, input ax_out, ay_out, joy_out, emu_active);
  modport slave  (input joya, joy_in, output ax_out, ay_out, joy_out, emu_active);
endinterface

// File: rtl/analog_axis_emu_axis_accum.sv
// One saturating axis accumulator with clear, restart-from-zero load and
// 1-LSB recentering decay.
module axis_accum
  import analog_axis_pkg::*;
#(
  parameter int AXW = 8
) (
  input  logic                  CLK_VIDEO,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  add,
  input  logic                  restart,
  input  logic                  dec,
  input  logic signed [31:0]    step,
  output logic signed [AXW-1:0] acc
);

  logic signed [31:0] base;

  always_comb base = restart ? '0 : 32'(acc);

  always_ff @(posedge CLK_VIDEO) begin
    if (reset || clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= AXW'(sat_add(base, step, AXW));
    end else if (dec && (acc != '0)) begin
      acc <= acc[AXW-1] ? acc + AXW'(1) : acc - AXW'(1);
    end
  end

endmodule

// File: rtl/analog_axis_emu.sv
// Mouse-to-analog-axis emulator: PS/2 motion drives one selected joystick
// port's axes and fire bits until the stick, halt, port change or idle exit.
module analog_axis_emu
  import analog_axis_pkg::*;
#(
  parameter  int NPORT      = 2,
  parameter  int AXW        = 8,
  parameter  int MAX_STEP   = 10,
  parameter  int SENS_SHIFT = 1,
  parameter  int TIMEOUT    = 0,
  parameter  int DECAY_DIV  = 0,
  parameter  int INV_Y      = 0,
  localparam int PW         = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic              CLK_VIDEO,
  input  logic              reset,
  input  logic [24:0]       ps2_mouse,
  input  logic [PW-1:0]     mouse_port,
  input  logic              hold,
  input  logic              decay_en,
  analog_axis_emu_if.slave  joy
);

  state_t                state_q, state_d;
  logic [PW-1:0]         act_port_q;
  logic                  stb_q, stb;
  logic [31:0]           idle_q, dcnt_q;
  logic                  enter, leave, exit_c, blk_entry, port_ok;
  logic                  timeout_hit, tick, acc_add, acc_dec;
  logic signed [31:0]    sh_x, sh_y, step_x, step_y;
  logic signed [AXW-1:0] acc_x, acc_y;
  logic [15:0]           joya_act, joya_new;

  assign stb = ps2_mouse[PS2_STB] ^ stb_q;

  always_comb begin
    sh_x = 32'(signed'({ps2_mouse[PS2_XSIGN], ps2_mouse[PS2_DX_LSB +: 8]})) >>> SENS_SHIFT;
    sh_y = 32'(signed'({ps2_mouse[PS2_YSIGN], ps2_mouse[PS2_DY_LSB +: 8]})) >>> SENS_SHIFT;
    if (INV_Y != 0) sh_y = -sh_y;
    step_x = clamp_step(sh_x, MAX_STEP);
    step_y = clamp_step(sh_y, MAX_STEP);
  end

  // Stick of the active port gates exit; stick of the requested port gates entry.
  always_comb begin
    joya_act = '0;
    joya_new = '0;
    port_ok  = 1'b0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (act_port_q == PW'(p)) joya_act = joy.joya[p*16 +: 16];
      if (mouse_port == PW'(p)) begin
        joya_new = joy.joya[p*16 +: 16];
        port_ok  = 1'b1;
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (idle_q == 32'(TIMEOUT - 1));
  assign tick        = decay_en && (DECAY_DIV != 0) && (dcnt_q == 32'(DECAY_DIV - 1));
  assign exit_c      = (joya_act != '0) || hold || (mouse_port != act_port_q) || timeout_hit;
  assign blk_entry   = (joya_new != '0) || hold || !port_ok;

  always_comb begin
    state_d = state_q;
    enter   = 1'b0;
    leave   = 1'b0;
    unique case (state_q)
      JOY:   if (stb && !blk_entry) begin state_d = MOUSE; enter = 1'b1; end
      MOUSE: if (exit_c) begin state_d = JOY; leave = 1'b1; end
    endcase
  end

  assign acc_add = stb && (enter || ((state_q == MOUSE) && !exit_c));
  assign acc_dec = (state_q == MOUSE) && !exit_c && !stb && tick;

  always_ff @(posedge CLK_VIDEO) begin
    stb_q <= ps2_mouse[PS2_STB];
    if (reset) begin
      state_q    <= JOY;
      act_port_q <= '0;
      idle_q     <= '0;
      dcnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (enter) act_port_q <= mouse_port;
      if ((state_q != MOUSE) || leave || stb) idle_q <= '0;
      else                                    idle_q <= idle_q + 32'd1;
      if ((state_q != MOUSE) || leave || !decay_en || (DECAY_DIV == 0) || tick) dcnt_q <= '0;
      else                                                                      dcnt_q <= dcnt_q + 32'd1;
    end
  end

  axis_accum #(.AXW(AXW)) u_acc_x (
    .CLK_VIDEO(CLK_VIDEO), .reset(reset), .clr(leave), .add(acc_add),
    .restart(enter), .dec(acc_dec), .step(step_x), .acc(acc_x)
  );

  axis_accum #(.AXW(AXW)) u_acc_y (
    .CLK_VIDEO(CLK_VIDEO), .reset(reset), .clr(leave), .add(acc_add),
    .restart(enter), .dec(acc_dec), .step(step_y), .acc(acc_y)
  );

  always_comb begin
    joy.ax_out     = '0;
    joy.ay_out     = '0;
    joy.joy_out    = '0;
    joy.emu_active = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      joy.ax_out[p*AXW +: AXW] = AXW'(signed'(joy.joya[p*16 +: 8]));
      joy.ay_out[p*AXW +: AXW] = AXW'(signed'(joy.joya[p*16+8 +: 8]));
      joy.joy_out[p*21 +: 21]  = joy.joy_in[p*21 +: 21];
      if ((state_q == MOUSE) && (act_port_q == PW'(p))) begin
        joy.ax_out[p*AXW +: AXW]  = acc_x;
        joy.ay_out[p*AXW +: AXW]  = acc_y;
        joy.joy_out[p*21+4 +: 2]  = ps2_mouse[PS2_BTN_LSB +: 2];
        joy.emu_active[p]         = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_analog_axis_emu.sv
// Scenario bench for analog_axis_emu with an arithmetic reference model.
module tb_analog_axis_emu;

  localparam int NPORT = 2;
  localparam int AXW   = 8;

  logic        CLK_VIDEO  = 1'b0;
  logic        reset      = 1'b1;
  logic [24:0] ps2_mouse  = '0;
  logic [0:0]  mouse_port = '0;
  logic        hold       = 1'b0;
  logic        decay_en   = 1'b0;

  int total = 0;
  int bad   = 0;
  int m_ax  = 0;
  int m_ay  = 0;

  analog_axis_emu_if #(.NPORT(NPORT), .AXW(AXW)) jif ();

  analog_axis_emu #(
    .NPORT(NPORT), .AXW(AXW), .MAX_STEP(10), .SENS_SHIFT(1),
    .TIMEOUT(100), .DECAY_DIV(4), .INV_Y(0)
  ) dut (
    .CLK_VIDEO(CLK_VIDEO), .reset(reset), .ps2_mouse(ps2_mouse),
    .mouse_port(mouse_port), .hold(hold), .decay_en(decay_en), .joy(jif)
  );

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  // Reference: floor-halve the signed delta, clamp to +-10, saturate to 8 bits.
  function automatic int step_of(input int raw);
    int s;
    s = (raw < 0) ? -((1 - raw) / 2) : raw / 2;
    if (s > 10) s = 10;
    if (s < -10) s = -10;
    return s;
  endfunction

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int ax_of(input int p);
    return int'($signed(jif.ax_out[p*AXW +: AXW]));
  endfunction

  function automatic int ay_of(input int p);
    return int'($signed(jif.ay_out[p*AXW +: AXW]));
  endfunction

  task automatic step_clk();
    @(posedge CLK_VIDEO);
    #1;
  endtask

  task automatic send(input int dx, input int dy, input logic [1:0] btn);
    ps2_mouse[24]    = ~ps2_mouse[24];
    ps2_mouse[4]     = (dx < 0);
    ps2_mouse[15:8]  = 8'(dx);
    ps2_mouse[5]     = (dy < 0);
    ps2_mouse[23:16] = 8'(dy);
    ps2_mouse[1:0]   = btn;
    step_clk();
  endtask

  task automatic test_reset();
    jif.joya   = '0;
    jif.joy_in = 42'({$urandom(), $urandom()});
    reset = 1'b1;
    step_clk();
    step_clk();
    total++; if (jif.emu_active !== 2'b00) begin bad++; $display("FAIL reset_active got=%b exp=00", jif.emu_active); end
    total++; if (jif.joy_out !== jif.joy_in) begin bad++; $display("FAIL reset_joy got=%h exp=%h", jif.joy_out, jif.joy_in); end
    total++; if (jif.ax_out !== 16'h0000) begin bad++; $display("FAIL reset_ax got=%h exp=0000", jif.ax_out); end
    reset = 1'b0;
    step_clk();
    total++; if (jif.emu_active !== 2'b00) begin bad++; $display("FAIL post_reset_edge got=%b exp=00", jif.emu_active); end
  endtask

  task automatic test_first_packet();
    send(40, 0, 2'b00);
    m_ax = 10; m_ay = 0;
    total++; if (ax_of(0) !== 10) begin bad++; $display("FAIL first_ax got=%0d exp=10", ax_of(0)); end
    total++; if (jif.emu_active !== 2'b01) begin bad++; $display("FAIL first_active got=%b exp=01", jif.emu_active); end
    total++; if (ay_of(0) !== 0) begin bad++; $display("FAIL first_ay got=%0d exp=0", ay_of(0)); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      send(40, 0, 2'b00);
      m_ax = sat8(m_ax + step_of(40));
      total++; if (ax_of(0) !== m_ax) begin bad++; $display("FAIL sat_up[%0d] got=%0d exp=%0d", i, ax_of(0), m_ax); end
    end
    total++; if (ax_of(0) !== 127) begin bad++; $display("FAIL sat_hi got=%0d exp=127", ax_of(0)); end
    for (int i = 0; i < 30; i++) begin
      send(-256, 0, 2'b00);
      m_ax = sat8(m_ax + step_of(-256));
      total++; if (ax_of(0) !== m_ax) begin bad++; $display("FAIL sat_dn[%0d] got=%0d exp=%0d", i, ax_of(0), m_ax); end
    end
    total++; if (ax_of(0) !== -128) begin bad++; $display("FAIL sat_lo got=%0d exp=-128", ax_of(0)); end
  endtask

  task automatic test_stick_exit();
    jif.joya = 32'h0000_0005;
    step_clk();
    total++; if (jif.emu_active !== 2'b00) begin bad++; $display("FAIL stick_active got=%b exp=00", jif.emu_active); end
    total++; if (ax_of(0) !== 5) begin bad++; $display("FAIL stick_ax got=%0d exp=5", ax_of(0)); end
    jif.joya = '0;
    send(40, 0, 2'b00);
    m_ax = 10;
    total++; if (ax_of(0) !== 10) begin bad++; $display("FAIL stick_resume got=%0d exp=10", ax_of(0)); end
    total++; if (jif.emu_active !== 2'b01) begin bad++; $display("FAIL stick_reenter got=%b exp=01", jif.emu_active); end
  endtask

  task automatic test_timeout();
    send(2, 0, 2'b00);
    for (int i = 1; i < 100; i++) step_clk();
    total++; if (jif.emu_active !== 2'b01) begin bad++; $display("FAIL to_99 got=%b exp=01", jif.emu_active); end
    step_clk();
    total++; if (jif.emu_active !== 2'b00) begin bad++; $display("FAIL to_100 got=%b exp=00", jif.emu_active); end
    send(2, 0, 2'b00);
    for (int i = 1; i < 99; i++) step_clk();
    send(2, 0, 2'b00);
    step_clk();
    total++; if (jif.emu_active !== 2'b01) begin bad++; $display("FAIL to_extend got=%b exp=01", jif.emu_active); end
    for (int i = 2; i < 100; i++) step_clk();
    total++; if (jif.emu_active !== 2'b01) begin bad++; $display("FAIL to_ext_99 got=%b exp=01", jif.emu_active); end
    step_clk();
    total++; if (jif.emu_active !== 2'b00) begin bad++; $display("FAIL to_ext_100 got=%b exp=00", jif.emu_active); end
  endtask

  task automatic test_decay();
    int exp_v;
    decay_en = 1'b1;
    send(40, 0, 2'b00);
    total++; if (ax_of(0) !== 10) begin bad++; $display("FAIL decay_start got=%0d exp=10", ax_of(0)); end
    for (int k = 1; k <= 45; k++) begin
      step_clk();
      exp_v = 10 - k / 4;
      if (exp_v < 0) exp_v = 0;
      total++; if (ax_of(0) !== exp_v) begin bad++; $display("FAIL decay[%0d] got=%0d exp=%0d", k, ax_of(0), exp_v); end
    end
    step_clk();
    step_clk();
    send(40, 0, 2'b00);
    total++; if (ax_of(0) !== 10) begin bad++; $display("FAIL decay_stb_tick got=%0d exp=10", ax_of(0)); end
    for (int k = 0; k < 4; k++) step_clk();
    total++; if (ax_of(0) !== 9) begin bad++; $display("FAIL decay_next got=%0d exp=9", ax_of(0)); end
    decay_en = 1'b0;
    hold = 1'b1;
    step_clk();
    total++; if (jif.emu_active !== 2'b00) begin bad++; $display("FAIL decay_hold got=%b exp=00", jif.emu_active); end
    hold = 1'b0;
  endtask

  task automatic test_port_buttons();
    logic [20:0] exp_p1;
    jif.joy_in = 42'({$urandom(), $urandom()});
    mouse_port = 1'b1;
    send(40, -20, 2'b01);
    exp_p1 = jif.joy_in[41:21];
    exp_p1[5:4] = 2'b01;
    total++; if (jif.emu_active !== 2'b10) begin bad++; $display("FAIL p1_active got=%b exp=10", jif.emu_active); end
    total++; if (jif.joy_out[41:21] !== exp_p1) begin bad++; $display("FAIL p1_joy got=%h exp=%h", jif.joy_out[41:21], exp_p1); end
    total++; if (jif.joy_out[20:0] !== jif.joy_in[20:0]) begin bad++; $display("FAIL p0_joy got=%h exp=%h", jif.joy_out[20:0], jif.joy_in[20:0]); end
    total++; if (ax_of(1) !== step_of(40)) begin bad++; $display("FAIL p1_ax got=%0d exp=%0d", ax_of(1), step_of(40)); end
    total++; if (ay_of(1) !== step_of(-20)) begin bad++; $display("FAIL p1_ay got=%0d exp=%0d", ay_of(1), step_of(-20)); end
    hold = 1'b1;
    step_clk();
    total++; if (jif.emu_active !== 2'b00) begin bad++; $display("FAIL hold_active got=%b exp=00", jif.emu_active); end
    total++; if (jif.joy_out !== jif.joy_in) begin bad++; $display("FAIL hold_joy got=%h exp=%h", jif.joy_out, jif.joy_in); end
    total++; if (ax_of(1) !== 0) begin bad++; $display("FAIL hold_ax got=%0d exp=0", ax_of(1)); end
    hold = 1'b0;
    step_clk();
    send(40, 0, 2'b10);
    total++; if (jif.emu_active !== 2'b10) begin bad++; $display("FAIL p1_reenter got=%b exp=10", jif.emu_active); end
    mouse_port = 1'b0;
    step_clk();
    total++; if (jif.emu_active !== 2'b00) begin bad++; $display("FAIL port_change got=%b exp=00", jif.emu_active); end
  endtask

  task automatic test_reset_mid();
    send(40, 0, 2'b00);
    total++; if (jif.emu_active !== 2'b01) begin bad++; $display("FAIL rmid_enter got=%b exp=01", jif.emu_active); end
    reset = 1'b1;
    ps2_mouse[24] = ~ps2_mouse[24];
    step_clk();
    total++; if (jif.emu_active !== 2'b00) begin bad++; $display("FAIL rmid_active got=%b exp=00", jif.emu_active); end
    total++; if (ax_of(0) !== 0) begin bad++; $display("FAIL rmid_ax got=%0d exp=0", ax_of(0)); end
    reset = 1'b0;
    step_clk();
    total++; if (jif.emu_active !== 2'b00) begin bad++; $display("FAIL rmid_no_edge got=%b exp=00", jif.emu_active); end
  endtask

  task automatic test_random();
    int dx, dy, gap, jx, jy;
    logic [1:0] btn;
    m_ax = 0; m_ay = 0;
    for (int i = 0; i < 60; i++) begin
      dx  = int'($urandom_range(511, 0)) - 256;
      dy  = int'($urandom_range(511, 0)) - 256;
      btn = 2'($urandom());
      send(dx, dy, btn);
      m_ax = sat8(m_ax + step_of(dx));
      m_ay = sat8(m_ay + step_of(dy));
      total++; if (ax_of(0) !== m_ax) begin bad++; $display("FAIL rnd_ax[%0d] got=%0d exp=%0d", i, ax_of(0), m_ax); end
      total++; if (ay_of(0) !== m_ay) begin bad++; $display("FAIL rnd_ay[%0d] got=%0d exp=%0d", i, ay_of(0), m_ay); end
      total++; if (jif.joy_out[5:4] !== btn) begin bad++; $display("FAIL rnd_btn[%0d] got=%b exp=%b", i, jif.joy_out[5:4], btn); end
      gap = int'($urandom_range(3, 0));
      for (int g = 0; g < gap; g++) begin
        jx = int'($urandom_range(255, 0));
        jy = int'($urandom_range(255, 0));
        jif.joya[31:16] = {8'(jy), 8'(jx)};
        step_clk();
        if (jx > 127) jx = jx - 256;
        if (jy > 127) jy = jy - 256;
        total++; if (ax_of(1) !== jx || ay_of(1) !== jy) begin bad++; $display("FAIL rnd_pass[%0d] got=%0d,%0d exp=%0d,%0d", i, ax_of(1), ay_of(1), jx, jy); end
      end
      total++; if (jif.emu_active !== 2'b01) begin bad++; $display("FAIL rnd_active[%0d] got=%b exp=01", i, jif.emu_active); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_packet();
    test_saturation();
    test_stick_exit();
    test_timeout();
    test_decay();
    test_port_buttons();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
